song_streamer: RTL and testbench
================================

Name: song_streamer

Overview:
- Parametrised sample sequencer that streams song audio from a synchronous sample ROM into the audio controller's output handshake.
- Successor to the fixed mono 16-bit-address player. Adds:
  - configurable sample width, address width and song length
  - mono or interleaved-stereo ROM layout
  - sample-repeat rate division
  - loop/one-shot modes, a done flag and a play-position readout
- Sits between the song ROM and the audio controller. Gameplay logic drives play/pause/stop.

Parameters:
- SAMPLE_W, 32: bit width of one ROM word and of each output channel.
- ADDR_W, 16: ROM address width.
- SONG_LEN, 65536: number of ROM words in the song; must be ≤ 2^ADDR_W and a multiple of CHANNELS.
- CHANNELS, 1: 1 = mono (each word feeds both outputs); 2 = stereo (even address left, odd address right).
- RATE_DIV, 1: each ROM frame is written to the codec RATE_DIV times before advancing; range 1..255.
- ROM_LAT, 1: ROM read latency in clk cycles, address to valid rom_q; range 1..3.
- LOOP, 0: 1 = wrap to address 0 after the last frame; 0 = stop at end and flag done.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- play  in  1  single-cycle start pulse; ignored while PLAY or PAUSED
- pause  in  1  level; freezes playback while high
- stop  in  1  level; synchronous abort to IDLE, overrides all else
- rom_addr  out  ADDR_W  ROM read address
- rom_q  in  SAMPLE_W  ROM read data
- out_allowed  in  1  codec output FIFO has space
- out_write  out  1  write strobe to codec
- left_out  out  SAMPLE_W  left sample
- right_out  out  SAMPLE_W  right sample
- playing  out  1  high in FETCH, PLAY, PAUSED
- done  out  1  high in DONE
- position  out  ADDR_W  address of the frame currently presented

Behaviour:
- Reset (resetn low, asynchronous):
  - state goes to IDLE
  - ptr, rom_addr, position and repeat counter are 0
  - left_out and right_out are 0
  - out_write, playing and done are 0
- States: IDLE, FETCH, PLAY, PAUSED, DONE.
- IDLE:
  - Outputs hold 0.
  - play=1 → FETCH with ptr=0.
- FETCH:
  - rom_addr=ptr. Wait ROM_LAT cycles, then capture rom_q into left_out.
  - CHANNELS=2: then set rom_addr=ptr+1, wait ROM_LAT cycles, capture into right_out.
  - CHANNELS=1: right_out gets the same value as left_out.
  - Repeat counter clears, then → PLAY. FETCH lasts ROM_LAT×CHANNELS+1 cycles.
- PLAY:
  - out_write = out_allowed (combinational, gated by state==PLAY and pause=0). The sample registers are stable whenever out_write=1.
  - Each cycle with out_write=1, the repeat counter increments.
  - On the write where repeat == RATE_DIV-1:
    - ptr += CHANNELS
    - if ptr+CHANNELS == SONG_LEN: LOOP=1 sets ptr=0; LOOP=0 → DONE
    - otherwise → FETCH
  - pause=1 → PAUSED.
- PAUSED:
  - out_write=0. Samples, ptr and repeat counter are frozen.
  - pause=0 → PLAY.
  - A pause asserted during FETCH completes the fetch, then enters PAUSED instead of PLAY.
- DONE:
  - out_write=0, done=1, last samples held.
  - play → FETCH with ptr=0.
- stop=1 in any state:
  - next cycle: IDLE, ptr=0, samples=0
  - stop has priority over play and pause in the same cycle
- position updates when a new frame is captured, not when rom_addr changes.
- Address arithmetic is unsigned ADDR_W. SONG_LEN = 2^ADDR_W wraps naturally with no overflow fault.

Optional Feature:
- Macro: SONG_STREAMER_VOLUME_EN
- Defined:
  - Adds input port vol_shift [2:0].
  - left_out and right_out are the captured samples arithmetically right-shifted by vol_shift (sign-preserving).
  - vol_shift is sampled once per frame at capture time, so a mid-frame change takes effect on the next frame.
- Undefined: no port is added and samples pass through unshifted.

Test Plan:
- Mono, RATE_DIV=1, LOOP=0, SONG_LEN=4, ROM[i]=i+1, out_allowed=1 → write sequence L=R=1,2,3,4; done=1 after the 4th write; out_write=0 thereafter.
- CHANNELS=2, SONG_LEN=4, ROM={A,B,C,D} → writes (L=A,R=B), then (L=C,R=D); position 0 then 2.
- RATE_DIV=3, mono, ROM={5,9} → writes 5,5,5,9,9,9. Holding out_allowed low for 10 cycles mid-frame inserts no extra writes and loses none.
- LOOP=1, SONG_LEN=2, ROM={7,8} → 7,8,7,8,... continuously; done stays 0; position wraps 1→0.
- Pause asserted after the 2nd write for 20 cycles → zero writes during the pause; 3rd write equals ROM[2]. stop mid-song → next cycle IDLE with outputs 0; play restarts from ROM[0].
- Async resetn low during FETCH with ROM_LAT=3 → all outputs 0 immediately without waiting for a clk edge; play after release behaves as from power-up.

Source files
------------

// File: rtl/song_streamer.sv
// Song sample sequencer: fetches mono or stereo frames from a pipelined ROM and
// writes each frame RATE_DIV times to the codec. Optional macro SONG_STREAMER_VOLUME_EN adds vol_shift.
module song_streamer #(
    parameter int SAMPLE_W = 32,
    parameter int ADDR_W   = 16,
    parameter int SONG_LEN = 65536,
    parameter int CHANNELS = 1,
    parameter int RATE_DIV = 1,
    parameter int ROM_LAT  = 1,
    parameter int LOOP     = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                play,
    input  logic                pause,
    input  logic                stop,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    input  logic                out_allowed,
`ifdef SONG_STREAMER_VOLUME_EN
    input  logic [2:0]          vol_shift,
`endif
    output logic                out_write,
    output logic [SAMPLE_W-1:0] left_out,
    output logic [SAMPLE_W-1:0] right_out,
    output logic                playing,
    output logic                done,
    output logic [ADDR_W-1:0]   position
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_PAUSED, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(SONG_LEN - CHANNELS);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(CHANNELS);
    localparam logic [2:0]        CAP_L    = 3'(ROM_LAT);
    localparam logic [2:0]        CAP_END  = 3'(ROM_LAT * CHANNELS);
    localparam logic [2:0]        ADDR_R   = 3'(ROM_LAT - 1);
    localparam logic [7:0]        REP_LAST = 8'(RATE_DIV - 1);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d, addr_q, addr_d, pos_q, pos_d;
    logic [7:0]            rep_q, rep_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]   left_q, left_d, right_q, right_d;
    logic [SAMPLE_W-1:0]   cap_l, cap_r;
    logic                  wr;
`ifdef SONG_STREAMER_VOLUME_EN
    logic [2:0]            vol_q, vol_d;

    // Right channel reuses the shift latched with the left word so a frame is scaled uniformly.
    always_comb begin
        cap_l = SAMPLE_W'($signed(rom_q) >>> vol_shift);
        cap_r = SAMPLE_W'($signed(rom_q) >>> vol_q);
    end
`else
    always_comb begin
        cap_l = rom_q;
        cap_r = rom_q;
    end
`endif

    assign wr        = (state_q == S_PLAY) && !pause && !stop && out_allowed;
    assign out_write = wr;
    assign rom_addr  = addr_q;
    assign left_out  = left_q;
    assign right_out = right_q;
    assign position  = pos_q;
    assign playing   = (state_q == S_FETCH) || (state_q == S_PLAY) || (state_q == S_PAUSED);
    assign done      = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        pos_d   = pos_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        right_d = right_q;
`ifdef SONG_STREAMER_VOLUME_EN
        vol_d   = vol_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (play) begin
                    state_d = S_FETCH;
                    ptr_d   = '0;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                cnt_d = cnt_q + 3'd1;
                // Pipelined ROM: the right address goes out exactly as the left data lands.
                if (CHANNELS == 2 && cnt_q == ADDR_R)
                    addr_d = ptr_q + ADDR_W'(1);
                if (cnt_q == CAP_L) begin
                    left_d = cap_l;
                    if (CHANNELS == 1)
                        right_d = cap_l;
`ifdef SONG_STREAMER_VOLUME_EN
                    vol_d = vol_shift;
`endif
                end
                if (CHANNELS == 2 && cnt_q == CAP_END)
                    right_d = cap_r;
                if (cnt_q == CAP_END) begin
                    rep_d   = '0;
                    pos_d   = ptr_q;
                    state_d = pause ? S_PAUSED : S_PLAY;
                end
            end
            S_PLAY: begin
                if (pause) begin
                    state_d = S_PAUSED;
                end else if (wr) begin
                    if (rep_q == REP_LAST) begin
                        rep_d = '0;
                        ptr_d = ptr_q + STEP;
                        cnt_d = '0;
                        if (ptr_q == LAST_PTR && LOOP == 0) begin
                            state_d = S_DONE;
                        end else begin
                            if (ptr_q == LAST_PTR)
                                ptr_d = '0;
                            addr_d  = ptr_d;
                            state_d = S_FETCH;
                        end
                    end else begin
                        rep_d = rep_q + 8'd1;
                    end
                end
            end
            S_PAUSED: begin
                if (!pause)
                    state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
        endcase
        if (stop) begin
            state_d = S_IDLE;
            ptr_d   = '0;
            addr_d  = '0;
            pos_d   = '0;
            rep_d   = '0;
            cnt_d   = '0;
            left_d  = '0;
            right_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            pos_q   <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
`ifdef SONG_STREAMER_VOLUME_EN
            vol_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            pos_q   <= pos_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            right_q <= right_d;
`ifdef SONG_STREAMER_VOLUME_EN
            vol_q   <= vol_d;
`endif
        end
    end
endmodule

// File: tb/tb_song_streamer.sv
// Scoreboard bench: a stereo one-shot player (A) and a mono looping player (B)
// share control inputs; expected write sequences are queued when play is issued.
module tb_song_streamer;
    logic clk = 1'b0;
    logic resetn, play, pause, stop, oa;

    logic [2:0]  addr_a, pos_a;
    logic [15:0] q_a, l_a, r_a;
    logic        wr_a, pl_a, dn_a;
    logic [1:0]  addr_b, pos_b;
    logic [15:0] q_b, l_b, r_b, b1, b2;
    logic        wr_b, pl_b, dn_b;

    logic [15:0] mem_a [8];
    logic [15:0] mem_b [4];

    typedef struct { int l; int r; int pos; } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int total = 0, bad = 0, pops_a = 0, pops_b = 0, hold = 0;

    song_streamer #(.SAMPLE_W(16), .ADDR_W(3), .SONG_LEN(8), .CHANNELS(2),
                    .RATE_DIV(2), .ROM_LAT(1), .LOOP(0)) dut_a (
        .clk(clk), .resetn(resetn), .play(play), .pause(pause), .stop(stop),
        .rom_addr(addr_a), .rom_q(q_a), .out_allowed(oa),
`ifdef SONG_STREAMER_VOLUME_EN
        .vol_shift(3'd0),
`endif
        .out_write(wr_a), .left_out(l_a), .right_out(r_a),
        .playing(pl_a), .done(dn_a), .position(pos_a));

    song_streamer #(.SAMPLE_W(16), .ADDR_W(2), .SONG_LEN(4), .CHANNELS(1),
                    .RATE_DIV(3), .ROM_LAT(3), .LOOP(1)) dut_b (
        .clk(clk), .resetn(resetn), .play(play), .pause(pause), .stop(stop),
        .rom_addr(addr_b), .rom_q(q_b), .out_allowed(oa),
`ifdef SONG_STREAMER_VOLUME_EN
        .vol_shift(3'd0),
`endif
        .out_write(wr_b), .left_out(l_b), .right_out(r_b),
        .playing(pl_b), .done(dn_b), .position(pos_b));

    always #5 clk = ~clk;

    always @(posedge clk) q_a <= mem_a[addr_a];
    always @(posedge clk) begin
        b1  <= mem_b[addr_b];
        b2  <= b1;
        q_b <= b2;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && wr_a === 1'b1) begin
            exp_t e;
            chk("a_write_during_pause", {31'd0, pause}, 0);
            if (qa.size() == 0) begin
                chk("a_unexpected_write", 1, 0);
            end else begin
                e = qa.pop_front();
                pops_a++;
                chk("a_left", {16'd0, l_a}, e.l);
                chk("a_right", {16'd0, r_a}, e.r);
                chk("a_position", {29'd0, pos_a}, e.pos);
            end
        end
    end

    always @(negedge clk) begin
        if (resetn === 1'b1 && wr_b === 1'b1) begin
            exp_t e;
            if (qb.size() == 0) begin
                chk("b_unexpected_write", 1, 0);
            end else begin
                e = qb.pop_front();
                pops_b++;
                chk("b_left", {16'd0, l_b}, e.l);
                chk("b_right", {16'd0, r_b}, e.r);
                chk("b_position", {30'd0, pos_b}, e.pos);
            end
        end
    end

    // Stereo one-shot: each frame (even=left, odd=right) repeated twice, then silence.
    task automatic push_a();
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 2; k++)
                qa.push_back('{int'(mem_a[2*f]), int'(mem_a[2*f+1]), 2*f});
    endtask

    // Mono loop: write n plays frame (n/3) mod 4 on both channels, forever.
    task automatic push_b();
        for (int n = 0; n < 600; n++)
            qb.push_back('{int'(mem_b[(n/3)%4]), int'(mem_b[(n/3)%4]), (n/3)%4});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (hold > 0) begin
            oa = 1'b0;
            hold--;
        end else begin
            oa = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_l_a"}, {16'd0, l_a}, 0);
        chk({tag, "_r_a"}, {16'd0, r_a}, 0);
        chk({tag, "_pos_a"}, {29'd0, pos_a}, 0);
        chk({tag, "_addr_a"}, {29'd0, addr_a}, 0);
        chk({tag, "_flags_a"}, {29'd0, wr_a, pl_a, dn_a}, 0);
        chk({tag, "_l_b"}, {16'd0, l_b}, 0);
        chk({tag, "_r_b"}, {16'd0, r_b}, 0);
        chk({tag, "_pos_b"}, {30'd0, pos_b}, 0);
        chk({tag, "_addr_b"}, {30'd0, addr_b}, 0);
        chk({tag, "_flags_b"}, {29'd0, wr_b, pl_b, dn_b}, 0);
    endtask

    task automatic pulse_play();
        play = 1'b1;
        cyc();
        play = 1'b0;
    endtask

    task automatic run_until_a_empty(input string nm);
        int n = 0;
        while (qa.size() != 0 && n < 600) begin
            cyc();
            n++;
        end
        chk({nm, "_a_finished"}, {31'd0, qa.size() == 0}, 1);
    endtask

    initial begin
        bit paused = 0, held = 0;
        int n;
        for (int i = 0; i < 8; i++) mem_a[i] = 16'($urandom) | 16'h0001;
        for (int i = 0; i < 4; i++) mem_b[i] = 16'($urandom) | 16'h0001;
        resetn = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; oa = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        resetn = 1'b1;
        cyc();

        // Full one-shot song with a 20-cycle pause and a 10-cycle out_allowed stall.
        push_a(); push_b();
        pulse_play();
        n = 0;
        while (qa.size() != 0 && n < 600) begin
            if (pops_a == 2 && !paused) begin
                pause = 1'b1;
                repeat (20) cyc();
                chk("a_playing_while_paused", {31'd0, pl_a}, 1);
                pause = 1'b0;
                paused = 1;
            end
            if (pops_b >= 4 && !held) begin
                hold = 10;
                held = 1;
            end
            cyc();
            n++;
        end
        chk("seg1_a_finished", {31'd0, qa.size() == 0}, 1);
        repeat (10) cyc();
        chk("a_done", {31'd0, dn_a}, 1);
        chk("a_idle_after_done", {30'd0, pl_a, wr_a}, 0);
        chk("b_loop_not_done", {30'd0, pl_b, dn_b}, 2);

        // Replay from DONE; B keeps looping and ignores play. Then stop+play together.
        push_a();
        pulse_play();
        repeat (15) cyc();
        stop = 1'b1; play = 1'b1;
        cyc();
        stop = 1'b0; play = 1'b0;
        chk_zero("stop");
        qa.delete(); qb.delete();
        repeat (5) cyc();

        // Async reset while B is mid-fetch with a nonzero frame held.
        push_a(); push_b();
        pops_b = 0;
        pulse_play();
        n = 0;
        while (!(pops_b >= 2 && addr_b != pos_b && l_b != 0) && n < 300) begin
            cyc();
            n++;
        end
        chk("b_reached_fetch", {31'd0, n < 300}, 1);
        #2 resetn = 1'b0;
        #1 chk_zero("async_reset");
        repeat (2) cyc();
        qa.delete(); qb.delete();
        resetn = 1'b1;
        cyc();

        // Post-reset play behaves as from power-up.
        push_a(); push_b();
        pulse_play();
        run_until_a_empty("seg4");
        repeat (5) cyc();
        chk("a_done_again", {31'd0, dn_a}, 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("b_stopped", {30'd0, pl_b, wr_b}, 0);
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
endmodule
